mailbox_deserializer: RTL and testbench

MAILBOX_DESERIALIZER -- requirements
Module: mailbox_deserializer

---
 rtl/mailbox_pkg.sv | 13 +
 rtl/mailbox_idle_timer.sv | 39 +++
 rtl/mailbox_deserializer.sv | 121 ++++++++++++
 tb/tb_mailbox_deserializer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// Shared state encoding and default parameters for the mailbox deserializer.
package mailbox_pkg;

  localparam int unsigned DEF_WIDTH   = 64;
  localparam int unsigned DEF_BEATS   = 4;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

endpackage

// File: rtl/mailbox_idle_timer.sv
// Counts idle cycles while a partial message is held; flags expiry after TIMEOUT.
module mailbox_idle_timer
  import mailbox_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire_c
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_d;

  // Expiry fires in the cycle the count would reach TIMEOUT.
  assign expire_c = run && (idle_q == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    idle_d = idle_q;
    if (clear || expire_c) begin
      idle_d = '0;
    end else if (run) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

endmodule

// File: rtl/mailbox_deserializer.sv
// Assembles BEATS mailbox beats into one message, beat 0 in the LSBs.
// Optional inter-beat idle timeout enabled by MAILBOX_DESER_TIMEOUT_EN.
module mailbox_deserializer
  import mailbox_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned BEATS   = DEF_BEATS,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_bits,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*BEATS-1:0]   out_bits,
  output logic                     timeout_err
);

  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned MSG_W = WIDTH * BEATS;

  if (BEATS < 2 || TIMEOUT < 1) begin : g_param_check
    $error("mailbox_deserializer: BEATS must be >= 2 and TIMEOUT >= 1");
  end

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [MSG_W-1:0]   data_q;
  logic [MSG_W-1:0]   data_d;
  logic               in_fire;
  logic               out_fire;
  logic               expire_c;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == FULL);
  assign out_bits  = data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef MAILBOX_DESER_TIMEOUT_EN
  logic timer_run;
  logic timeout_err_q;
  logic timeout_err_d;

  // Idle time only accumulates while a partial message sits in COLLECT.
  assign timer_run     = in_ready && (cnt_q != '0) && !in_fire;
  assign timeout_err_d = expire_c;
  assign timeout_err   = timeout_err_q;

  mailbox_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clock    (clock),
    .reset    (reset),
    .run      (timer_run),
    .clear    (in_fire),
    .expire_c (expire_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign expire_c    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      COLLECT: begin
        if (in_fire) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              data_d[k*WIDTH +: WIDTH] = in_bits;
            end
          end
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (expire_c) begin
          cnt_d = '0;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload needs no reset: out_bits is only meaningful while FULL.
  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_mailbox_deserializer.sv
// Bench for mailbox_deserializer: queue-based message model checked every cycle,
// plus directed vectors with literal expected messages.
module tb_mailbox_deserializer;

  localparam int unsigned W  = 8;
  localparam int unsigned B  = 4;
  localparam int unsigned TO = 4;
  localparam int unsigned MW = W * B;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_bits;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_bits;
  logic          timeout_err;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int err_pulses = 0;
  int last_acc   = 0;

  mailbox_deserializer #(
    .WIDTH   (W),
    .BEATS   (B),
    .TIMEOUT (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Reference model: beats accumulate in a queue, a full queue becomes a pending message.
  logic [W-1:0]  m_beats[$];
  bit            m_full     = 1'b0;
  logic [MW-1:0] m_msg      = '0;
  bit            m_err      = 1'b0;
  int            m_msgs_out = 0;
`ifdef MAILBOX_DESER_TIMEOUT_EN
  int            m_idle     = 0;
`endif

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_beats.delete();
      m_full = 1'b0;
      m_err  = 1'b0;
`ifdef MAILBOX_DESER_TIMEOUT_EN
      m_idle = 0;
`endif
    end else begin
      m_err = 1'b0;
      if (m_full) begin
        if (out_ready) begin
          m_full = 1'b0;
          m_msgs_out++;
        end
      end else if (in_valid) begin
        m_beats.push_back(in_bits);
`ifdef MAILBOX_DESER_TIMEOUT_EN
        m_idle = 0;
`endif
        if (m_beats.size() == B) begin
          m_msg = '0;
          foreach (m_beats[k]) m_msg = m_msg | (MW'(m_beats[k]) << (W * k));
          m_beats.delete();
          m_full = 1'b1;
        end
      end
`ifdef MAILBOX_DESER_TIMEOUT_EN
      else if (m_beats.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_beats.delete();
          m_idle = 0;
          m_err  = 1'b1;
        end
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    chk("in_ready", 64'(in_ready), 64'(!m_full));
    chk("out_valid", 64'(out_valid), 64'(m_full));
    chk("timeout_err", 64'(timeout_err), 64'(m_err));
    if (m_full) chk("out_bits", 64'(out_bits), 64'(m_msg));
    if (timeout_err === 1'b1) err_pulses++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] d);
    bit acc;
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_bits  = d;
    do begin
      acc = in_ready;
      step();
      t++;
    end while (!acc && t < 200);
    chk("beat_accepted", 64'(acc), 64'd1);
    last_acc = cyc;
  endtask

  task automatic expect_msg(input string name, input logic [MW-1:0] exp);
    chk("msg_valid", 64'(out_valid), 64'd1);
    chk(name, 64'(out_bits), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_first1;
    int base_err;
    int base_msgs;
    int guard;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_bits   = '0;
    repeat (2) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    reset = 1'b0;

    // Back-to-back message with consumer ready, then throughput of the next one.
    out_ready = 1'b1;
    send_beat(8'h11);
    c_first1 = last_acc;
    send_beat(8'h22);
    send_beat(8'h33);
    send_beat(8'h44);
    in_valid = 1'b0;
    expect_msg("msg_44332211", 32'h44332211);
    step();
    chk("drained_in_ready", 64'(in_ready), 64'd1);
    send_beat(8'h01);
    chk("throughput", 64'(last_acc - c_first1), 64'(B + 1));
    send_beat(8'h02);
    send_beat(8'h03);
    send_beat(8'h04);
    in_valid = 1'b0;
    expect_msg("msg_04030201", 32'h04030201);
    step();

    // Consumer back-pressure: pending message holds, new beat waits for the out fire.
    out_ready = 1'b0;
    send_beat(8'h11);
    send_beat(8'h22);
    send_beat(8'h33);
    send_beat(8'h44);
    in_valid = 1'b1;
    in_bits  = 8'h55;
    repeat (10) begin
      step();
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_bits", 64'(out_bits), 64'h44332211);
    end
    out_ready = 1'b1;
    send_beat(8'h55);
    send_beat(8'h66);
    send_beat(8'h77);
    send_beat(8'h88);
    in_valid = 1'b0;
    expect_msg("msg_88776655", 32'h88776655);
    step();

`ifdef MAILBOX_DESER_TIMEOUT_EN
    base_err = err_pulses;
    send_beat(8'hEE);
    send_beat(8'hEF);
    in_valid = 1'b0;
    repeat (6) step();
    chk("timeout_pulse_count", 64'(err_pulses - base_err), 64'd1);
    send_beat(8'hA1);
    send_beat(8'hA2);
    send_beat(8'hA3);
    send_beat(8'hA4);
    in_valid = 1'b0;
    expect_msg("msg_A4A3A2A1", 32'hA4A3A2A1);
    step();

    base_err = err_pulses;
    send_beat(8'hB1);
    send_beat(8'hB2);
    in_valid = 1'b0;
    repeat (3) step();
    send_beat(8'hB3);
    send_beat(8'hB4);
    in_valid = 1'b0;
    expect_msg("msg_B4B3B2B1", 32'hB4B3B2B1);
    step();
    chk("beat_beats_timeout", 64'(err_pulses - base_err), 64'd0);
`else
    base_err = err_pulses;
    send_beat(8'hD1);
    send_beat(8'hD2);
    in_valid = 1'b0;
    repeat (10) step();
    send_beat(8'hD3);
    send_beat(8'hD4);
    in_valid = 1'b0;
    expect_msg("msg_D4D3D2D1", 32'hD4D3D2D1);
    step();
    chk("stall_no_timeout", 64'(err_pulses - base_err), 64'd0);
`endif

    // Reset mid-message and while FULL discards everything held.
    send_beat(8'h91);
    send_beat(8'h92);
    send_beat(8'h93);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    step();
    reset     = 1'b0;
    out_ready = 1'b0;
    send_beat(8'hC1);
    send_beat(8'hC2);
    send_beat(8'hC3);
    send_beat(8'hC4);
    in_valid = 1'b0;
    expect_msg("msg_C4C3C2C1", 32'hC4C3C2C1);
    reset = 1'b1;
    #1;
    chk("rst_full_out_valid", 64'(out_valid), 64'd0);
    chk("rst_full_in_ready", 64'(in_ready), 64'd1);
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    send_beat(8'hE1);
    send_beat(8'hE2);
    send_beat(8'hE3);
    send_beat(8'hE4);
    in_valid = 1'b0;
    expect_msg("msg_E4E3E2E1", 32'hE4E3E2E1);
    step();

    // Random handshake toggling; the per-cycle model compare tracks every beat.
    base_msgs = m_msgs_out;
    guard     = 0;
    while ((m_msgs_out - base_msgs) < 1000 && guard < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      in_bits   = W'($urandom);
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("random_msgs_done", 64'((m_msgs_out - base_msgs) >= 1000), 64'd1);

    out_ready = 1'b1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
